// File: rtl/mcc_add_scheduler.sv
// mcc_add_scheduler: round-robin time-sharing of one multi-cycle adder between NREQ requesters
// Ports: clk/rst (async, active-high); req_valid/req_a/req_b/req_ready request handshake;
// rsp_valid/rsp_sum one-hot result strobe and shared sum; add_a/add_b/add_s external adder;
// busy high while an operation is in flight; grant_id current or last grantee.
module mcc_add_scheduler #(
  parameter int NREQ = 4,
  parameter int WIDTH = 16,
  parameter int SETTLE = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ*WIDTH-1:0]              req_a,
  input  logic [NREQ*WIDTH-1:0]              req_b,
  output logic [NREQ-1:0]                    req_ready,
  output logic [NREQ-1:0]                    rsp_valid,
  output logic [WIDTH:0]                     rsp_sum,
  output logic [WIDTH-1:0]                   add_a,
  output logic [WIDTH-1:0]                   add_b,
  input  logic [WIDTH:0]                     add_s,
  output logic                               busy,
  output logic [(NREQ>1?$clog2(NREQ):1)-1:0] grant_id
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETTLE) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, win, idx;
  logic [CW-1:0] cnt;
  logic found, accept;
  // first valid requester scanning upward from rr_ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    accept = state == IDLE && found;
    req_ready = accept ? NREQ'(1) << win : '0;
    state_n = accept ? WAIT : (state == WAIT && cnt == '0) ? RESP : state == RESP ? IDLE : state;
  end
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP ? NREQ'(1) << grant_id : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // add_a/add_b load only on accept so the carry chain stays quiet between operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      cnt <= '0;
      add_a <= '0;
      add_b <= '0;
      rsp_sum <= '0;
      grant_id <= '0;
    end else if (accept) begin
      add_a <= req_a[win*WIDTH +: WIDTH];
      add_b <= req_b[win*WIDTH +: WIDTH];
      grant_id <= win;
      rr_ptr <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
      cnt <= CW'(SETTLE - 1);
    end else if (state == WAIT) begin
      if (cnt == '0) rsp_sum <= add_s;
      else cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_mcc_add_scheduler.sv
// tb_mcc_add_scheduler: scoreboard bench for the round-robin adder scheduler
module tb_mcc_add_scheduler;
  localparam int N = 4, W = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W:0] rsp_sum, add_s;
  logic [W-1:0] add_a, add_b;
  logic busy;
  logic [1:0] grant_id;
  int tests = 0, fails = 0, cyc = 0, start = 0;
  typedef struct {int id; logic [W:0] sum;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  int acc_id[$], acc_cyc[$];

  mcc_add_scheduler #(.NREQ(N), .WIDTH(W), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .add_a(add_a),
    .add_b(add_b), .add_s(add_s), .busy(busy), .grant_id(grant_id));

  // behavioural adder standing in for the external carry chain
  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic expect_rsp(input int i, input logic [W:0] s);
    sb.push_back('{i, s});
  endtask

  // wait for n accepts; keep=0 drops each requester's valid after its accept edge
  task automatic serve(input int n, input bit keep);
    int got = 0;
    logic [N-1:0] rdy;
    for (int t = 0; t < 100 && got < n; t++) begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy != '0) begin
        for (int i = 0; i < N; i++) if (rdy[i]) acc_id.push_back(i);
        acc_cyc.push_back(cyc - start);
        got++;
        @(posedge clk); #1;
        if (!keep) req_valid = req_valid & ~rdy;
      end
    end
    if (got < n) chk("serve_timeout", got, n);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  // monitor: every result strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        m_e = sb.pop_front();
        chk("rsp_valid", rsp_valid, N'(1) << m_e.id);
        chk("rsp_sum", rsp_sum, m_e.sum);
        chk("rsp_grant_id", grant_id, m_e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst = 0;
    // single op: accept cycle 0, busy 1..3, strobe cycle 3
    @(posedge clk); #1;
    set_req(0, 16'h1234, 16'h4321);
    expect_rsp(0, 17'h05555);
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0001);
    chk("single_busy0", busy, 0);
    @(posedge clk); #1 req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("single_busy", busy, 1);
      chk("single_strobe", rsp_valid, k == 3 ? 4'b0001 : 4'b0000);
      if (k == 1) chk("single_add_a", add_a, 16'h1234);
    end
    @(negedge clk);
    chk("single_busy4", busy, 0);
    // carry-out cases
    @(posedge clk); #1;
    set_req(1, 16'hFFFF, 16'h0001);
    expect_rsp(1, 17'h10000);
    serve(1, 0);
    repeat (4) @(posedge clk);
    #1;
    set_req(2, 16'hFFFF, 16'hFFFF);
    expect_rsp(2, 17'h1FFFE);
    serve(1, 0);
    repeat (4) @(posedge clk);
    // isolation: operands toggle with no valid request
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      @(negedge clk);
      chk("iso_ready", req_ready, 0);
      chk("iso_add_a", add_a, 16'hFFFF);
      chk("iso_add_b", add_b, 16'hFFFF);
    end
    // contention after reset: grants 0,1,2,3 at cycles 0,4,8,12
    pulse_reset();
    acc_id.delete(); acc_cyc.delete();
    for (int i = 0; i < N; i++) begin
      set_req(i, 16'(16'h1000 * (i + 1)), 16'(i + 1));
      expect_rsp(i, 17'(17'h1001 * (i + 1)));
    end
    start = cyc;
    serve(4, 0);
    for (int i = 0; i < N && i < acc_id.size(); i++) begin
      chk("cont_id", acc_id[i], i);
      chk("cont_cycle", acc_cyc[i], 4 * i);
    end
    repeat (5) @(posedge clk);
    // fairness: 1 and 3 continuously from rr_ptr=0
    pulse_reset();
    acc_id.delete(); acc_cyc.delete();
    set_req(1, 16'h0101, 16'h0202);
    set_req(3, 16'h8000, 16'h8000);
    for (int k = 0; k < 2; k++) begin
      expect_rsp(1, 17'h00303);
      expect_rsp(3, 17'h10000);
    end
    start = cyc;
    serve(4, 1);
    req_valid = '0;
    for (int i = 0; i < 4 && i < acc_id.size(); i++) chk("fair_id", acc_id[i], i % 2 ? 3 : 1);
    repeat (5) @(posedge clk);
    // reset during WAIT: result discarded, next grant from rr_ptr=0
    #1;
    set_req(2, 16'h00AA, 16'h0055);
    serve(1, 0);
    #2 rst = 1;
    #1;
    chk("mid_add_a", add_a, 0);
    chk("mid_add_b", add_b, 0);
    chk("mid_rsp_sum", rsp_sum, 0);
    chk("mid_grant_id", grant_id, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 0;
    acc_id.delete(); acc_cyc.delete();
    set_req(1, 16'h0011, 16'h0022);
    set_req(3, 16'h0100, 16'h0200);
    expect_rsp(1, 17'h00033);
    expect_rsp(3, 17'h00300);
    serve(2, 0);
    if (acc_id.size() == 2) begin
      chk("post_rst_first", acc_id[0], 1);
      chk("post_rst_second", acc_id[1], 3);
    end
    repeat (6) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcc_add_scheduler.md
Name: mcc_add_scheduler

Overview:
- Time-shares one external 16-bit Manchester-carry-chain adder between NREQ requesters.
- Round-robin arbitration and a valid/ready request handshake.
- The carry chain is a declared multi-cycle path, so the block holds operands stable for SETTLE cycles before sampling the sum.
- Operand isolation: adder inputs change only on a grant, never while idle, to suppress switching power in the chain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width; matches the adder instance
- SETTLE, 2, cycles operands are held before the sum is sampled (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_ready  out  NREQ  one-hot accept, combinational
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe
- rsp_sum  out  WIDTH+1  result incl. carry-out, shared by all requesters
- add_a  out  WIDTH  registered operand A to the adder
- add_b  out  WIDTH  registered operand B to the adder
- add_s  in  WIDTH+1  adder sum, carry-out in MSB
- busy  out  1  high in WAIT or RESP
- grant_id  out  clog2(NREQ)  index of the current or last grantee

Behaviour:
- Reset (async, immediate):
  - state = IDLE, rr_ptr = 0, cnt = 0.
  - add_a, add_b, rsp_sum and grant_id = 0.
  - rsp_valid = 0, busy = 0.
- FSM states:
  - IDLE: req_ready[i] = 1 only for the winner. The winner is the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, … mod NREQ. req_ready is all-zero if no request is valid or state != IDLE.
  - IDLE, on accept (req_valid[i] & req_ready[i]): register add_a/add_b from requester i, grant_id = i, rr_ptr = (i+1) mod NREQ, cnt = SETTLE-1, go to WAIT.
  - WAIT: add_a/add_b held. Decrement cnt; when cnt == 0, register rsp_sum = add_s and go to RESP.
  - RESP: rsp_valid[grant_id] = 1 for exactly this cycle, then go to IDLE.
- Latency: accept in cycle T, rsp_valid in cycle T+SETTLE+1.
- Throughput: one operation per SETTLE+2 cycles; no new accept in RESP.
- Handshake:
  - A requester holds req_valid and its operands stable until req_ready.
  - Dropping req_valid before accept is legal and loses nothing.
  - Operands sampled only at the accept edge; later changes are ignored.
- Operand isolation: add_a/add_b change only at an accept edge. Between operations they keep the last operands, so the adder sees no toggling while idle.
- rsp_sum holds its value until the next RESP; it is valid only when rsp_valid is set.
- Width: rsp_sum is the full WIDTH+1 value; no truncation or saturation. Carry-in is fixed 0 at the adder.
- Simultaneous events: several requests valid in IDLE → round-robin grants exactly one. rr_ptr advances only on accept and wraps NREQ-1 → 0.
- Reset mid-operation: the in-flight result is discarded and no rsp_valid is produced. Requesters re-issue.
- X on add_s is never sampled outside the WAIT→RESP edge.

Test Plan:
- Single op, NREQ=4, SETTLE=2: req 0 with a=0x1234, b=0x4321, accepted cycle 0 → rsp_valid=4'b0001 in cycle 3, rsp_sum=0x05555, busy in cycles 1..3.
- Carry-out: a=0xFFFF, b=0x0001 → rsp_sum=0x10000. a=b=0xFFFF → rsp_sum=0x1FFFE.
- Contention: all four req_valid set together after reset → accepts in cycles 0, 4, 8, 12 to requesters 0, 1, 2, 3. rsp_valid in cycles 3, 7, 11, 15; grant_id follows.
- Fairness/wrap: requesters 1 and 3 request continuously, rr_ptr=0 → grant order 1, 3, 1, 3. rr_ptr goes 2, 0, 2, 0.
- Isolation: req_valid=0 while req_a/req_b toggle randomly for 20 cycles → add_a/add_b unchanged and req_ready=0.
- Async reset in WAIT (cycle 1 after accept) → outputs zero immediately, no rsp_valid, and the next request is served from rr_ptr=0.
